// File: rtl/tdmi_rx_core.sv
`timescale 1ns/1ps
// tdmi_rx_core: 32-channel x 8-bit serial TDM receiver with frame-sync lock FSM and channel store.
// Latency: word_valid/word_data/frame_done register on the same edge as the 8th bit of a byte.
// Backpressure: none, the serial stream cannot be stalled; optional sticky sync_err under `TDMI_SYNC_ERR_EN.
module tdmi_rx_core (
    input  logic       serial_clk_inv,
    input  logic       reset,
    input  logic       data_in,
    input  logic       frame_sync_in,
    input  logic       sync_err_clr,
    input  logic [4:0] rd_ch,
    output logic [7:0] rd_data,
    output logic       word_valid,
    output logic [4:0] word_ch,
    output logic [7:0] word_data,
    output logic       word_toggle,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        fs_d_q;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  ch_cnt_q, ch_cnt_d;
    logic [1:0]  miss_cnt_q, miss_cnt_d;
    logic        word_valid_q, word_valid_d;
    logic [4:0]  word_ch_q, word_ch_d;
    logic [7:0]  word_data_q, word_data_d;
    logic        word_toggle_q, word_toggle_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        locked_q, locked_d;
    logic [7:0]  mem_q [32];

    logic        fs_edge;
    logic [7:0]  byte_nxt;
    logic        mem_we;
    logic        sync_set;
    logic [1:0]  miss_inc;

    assign fs_edge  = frame_sync_in & ~fs_d_q;
    assign byte_nxt = {shift_q[6:0], data_in};
    assign miss_inc = (miss_cnt_q == 2'd3) ? 2'd3 : miss_cnt_q + 2'd1;

    // Next-state: realign on any frame-sync rising edge, otherwise shift/count while locked
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        ch_cnt_d      = ch_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        word_valid_d  = 1'b0;
        word_ch_d     = word_ch_q;
        word_data_d   = word_data_q;
        word_toggle_d = word_toggle_q;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        mem_we        = 1'b0;
        sync_set      = 1'b0;

        if (fs_edge) begin
            // A sync anywhere but the expected frame start throws away the partial byte;
            // this also covers a sync landing on the last bit of channel 31.
            if ((state_q == LOCKED) && ((bit_cnt_q != 3'd0) || (ch_cnt_q != 5'd0)))
                sync_set = 1'b1;
            shift_d    = {7'b0, data_in};
            bit_cnt_d  = 3'd1;
            ch_cnt_d   = 5'd0;
            miss_cnt_d = 2'd0;
            state_d    = LOCKED;
        end else if (state_q == LOCKED) begin
            shift_d   = byte_nxt;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                mem_we        = 1'b1;
                word_valid_d  = 1'b1;
                word_ch_d     = ch_cnt_q;
                word_data_d   = byte_nxt;
                word_toggle_d = ~word_toggle_q;
                ch_cnt_d      = ch_cnt_q + 5'd1;
                if (ch_cnt_q == 5'd31) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                end
            end
            // Expected frame start passed without a sync pulse
            if ((bit_cnt_q == 3'd0) && (ch_cnt_q == 5'd0)) begin
                miss_cnt_d = miss_inc;
                if (miss_inc == 2'd2) begin
                    state_d  = HUNT;
                    sync_set = 1'b1;
                end
            end
        end

        locked_d = (state_d == LOCKED);
    end

    // Register FSM state, counters and all outputs
    always_ff @(posedge serial_clk_inv or posedge reset) begin
        if (reset) begin
            state_q       <= HUNT;
            fs_d_q        <= 1'b0;
            shift_q       <= 8'h00;
            bit_cnt_q     <= 3'd0;
            ch_cnt_q      <= 5'd0;
            miss_cnt_q    <= 2'd0;
            word_valid_q  <= 1'b0;
            word_ch_q     <= 5'd0;
            word_data_q   <= 8'h00;
            word_toggle_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= 8'h00;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fs_d_q        <= frame_sync_in;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            ch_cnt_q      <= ch_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            word_valid_q  <= word_valid_d;
            word_ch_q     <= word_ch_d;
            word_data_q   <= word_data_d;
            word_toggle_q <= word_toggle_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            locked_q      <= locked_d;
        end
    end

    // Channel store; cleared by reset, retained across HUNT
    always_ff @(posedge serial_clk_inv or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= 8'h00;
        end else if (mem_we) begin
            mem_q[ch_cnt_q] <= byte_nxt;
        end
    end

`ifdef TDMI_SYNC_ERR_EN
    logic sync_err_q, sync_err_d;

    // Sticky error: a set on the same edge as a clear wins
    always_comb begin
        sync_err_d = sync_set | (sync_err_q & ~sync_err_clr);
    end

    // Register sticky sync error
    always_ff @(posedge serial_clk_inv or posedge reset) begin
        if (reset) sync_err_q <= 1'b0;
        else       sync_err_q <= sync_err_d;
    end

    assign sync_err = sync_err_q;
`else
    logic unused_sync_err;
    assign unused_sync_err = sync_err_clr | sync_set;
    assign sync_err        = 1'b0;
`endif

    assign rd_data     = mem_q[rd_ch];
    assign word_valid  = word_valid_q;
    assign word_ch     = word_ch_q;
    assign word_data   = word_data_q;
    assign word_toggle = word_toggle_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign locked      = locked_q;

endmodule
